// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks destination/result-type tags for the E, M and W stages,
// derives the global stall, and selects the forwarding sources for the D-stage
// comparator, the E-stage ALU operands and the M-stage store data.
// Result types: 0 NW, 1 ALU (ready end of E), 2 DM (ready end of M),
// 3 PC (link value ready in D), 4-7 behave as NW.
// There is no FSM and no valid/ready handshake in this block; every output is
// a pure function of the registered tags and the current D-stage inputs.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [1:0] tuse_rs,
    input  logic [1:0] tuse_rt,
    input  logic [4:0] waD,
    input  logic [2:0] resD,
    input  logic       md_useD,
    input  logic       md_busy,
    output logic       stall,
    output logic [1:0] fwd_rsD,
    output logic [1:0] fwd_rtD,
    output logic [1:0] fwd_rsE,
    output logic [1:0] fwd_rtE,
    output logic       fwd_rtM,
    output logic [4:0] waE,
    output logic [4:0] waM,
    output logic [4:0] waW,
    output logic [2:0] resE,
    output logic [2:0] resM,
    output logic [2:0] resW
);

    localparam logic [2:0] RES_NW  = 3'd0;
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Operand tags carried along so E and M can pick their own forward sources.
    logic [4:0] rsE, rtE, rtM;

    logic [1:0] tnew_e, tnew_m;
    logic       rdy_e, rdy_m;
    logic       stall_rs, stall_rt;

    // Only ALU, DM and PC actually write the register file.
    function automatic logic is_write(input logic [2:0] res);
        return (res == RES_ALU) || (res == RES_DM) || (res == RES_PC);
    endfunction

    // A stage matches r when it will write r; $0 never matches.
    function automatic logic hits(input logic [4:0] wa, input logic [2:0] res,
                                  input logic [4:0] r);
        return (r != 5'd0) && (wa == r) && is_write(res);
    endfunction

    // D-stage select: youngest stage that both matches and already holds the value.
    function automatic logic [1:0] sel_d(input logic [4:0] r,
                                         input logic [4:0] wa_e, input logic [2:0] res_e,
                                         input logic [4:0] wa_m, input logic [2:0] res_m,
                                         input logic [4:0] wa_w, input logic [2:0] res_w);
        logic [1:0] sel;
        sel = 2'd0;
        if (hits(wa_e, res_e, r) && (res_e == RES_PC))
            sel = 2'd3;
        else if (hits(wa_m, res_m, r) && ((res_m == RES_ALU) || (res_m == RES_PC)))
            sel = 2'd1;
        else if (hits(wa_w, res_w, r))
            sel = 2'd2;
        return sel;
    endfunction

    // E-stage select: M if it holds a finished value, else W, else the pipe value.
    function automatic logic [1:0] sel_e(input logic [4:0] r,
                                         input logic [4:0] wa_m, input logic [2:0] res_m,
                                         input logic [4:0] wa_w, input logic [2:0] res_w);
        logic [1:0] sel;
        sel = 2'd0;
        if (hits(wa_m, res_m, r) && ((res_m == RES_ALU) || (res_m == RES_PC)))
            sel = 2'd1;
        else if (hits(wa_w, res_w, r))
            sel = 2'd2;
        return sel;
    endfunction

    // Cycles until each in-flight result becomes available.
    always_comb begin
        tnew_e = 2'd0;
        tnew_m = 2'd0;
        case (resE)
            RES_ALU: tnew_e = 2'd1;
            RES_DM:  tnew_e = 2'd2;
            default: tnew_e = 2'd0;
        endcase
        if (resM == RES_DM)
            tnew_m = 2'd1;
    end

    assign rdy_e = (resE == RES_PC);
    assign rdy_m = (resM == RES_ALU) || (resM == RES_PC);

    // Stall when a producer still needs more cycles than the consumer can wait.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (tuse_rs != TUSE_NONE)
            stall_rs = (hits(waE, resE, rsD) && (tnew_e > tuse_rs)) ||
                       (hits(waM, resM, rsD) && (tnew_m > tuse_rs));
        if (tuse_rt != TUSE_NONE)
            stall_rt = (hits(waE, resE, rtD) && (tnew_e > tuse_rt)) ||
                       (hits(waM, resM, rtD) && (tnew_m > tuse_rt));
        stall = stall_rs | stall_rt | (md_useD & md_busy);
    end

    // Forwarding selects for D comparator, E ALU and M store data.
    always_comb begin
        fwd_rsD = sel_d(rsD, waE, resE, waM, resM, waW, resW);
        fwd_rtD = sel_d(rtD, waE, resE, waM, resM, waW, resW);
        fwd_rsE = sel_e(rsE, waM, resM, waW, resW);
        fwd_rtE = sel_e(rtE, waM, resM, waW, resW);
        fwd_rtM = hits(waW, resW, rtM);
    end

    // Tag pipeline: flush on reset/clr, bubble into E on stall, else advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waE <= 5'd0; resE <= RES_NW; rsE <= 5'd0; rtE <= 5'd0;
            waM <= 5'd0; resM <= RES_NW; rtM <= 5'd0;
            waW <= 5'd0; resW <= RES_NW;
        end else if (clr) begin
            waE <= 5'd0; resE <= RES_NW; rsE <= 5'd0; rtE <= 5'd0;
            waM <= 5'd0; resM <= RES_NW; rtM <= 5'd0;
            waW <= 5'd0; resW <= RES_NW;
        end else begin
            if (stall) begin
                waE <= 5'd0; resE <= RES_NW; rsE <= 5'd0; rtE <= 5'd0;
            end else begin
                waE <= waD;  resE <= resD;   rsE <= rsD;  rtE <= rtD;
            end
            waM <= waE; resM <= resE; rtM <= rtE;
            waW <= waM; resW <= resM;
        end
    end

endmodule
